// File: rtl/sram_controller.sv
// sram_controller: bridges 32-bit MEM-stage word accesses onto a 16-bit
// asynchronous SRAM as two half-word accesses, high half first.
module sram_controller #(
   parameter int ADDR_BASE   = 1024,
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_r_en,
   input  logic                   mem_w_en,
   input  logic [31:0]            address,
   input  logic [31:0]            data,
   output logic [31:0]            data_memory_out,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_we_n,
   output logic [15:0]            sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_in
);

   localparam int IW = SRAM_ADDR_W - 1;

   typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

   state_t        state, state_nx;
   logic [3:0]    wait_cnt, wait_nx;
   logic          op_w;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic          req;
   logic          last;
   logic [IW-1:0] idx_in;
   logic [IW-1:0] idx_q;

   assign req    = mem_r_en | mem_w_en;
   assign last   = (wait_cnt == 4'(WAIT_CYCLES - 1));
   assign idx_in = IW'((address - 32'(ADDR_BASE)) >> 2);
   assign idx_q  = IW'((addr_q - 32'(ADDR_BASE)) >> 2);

   // State, counter, request latch, SRAM address and read-capture registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         op_w            <= 1'b0;
         addr_q          <= '0;
         data_q          <= '0;
         sram_addr       <= '0;
         data_memory_out <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         if (state == IDLE && req) begin
            op_w      <= mem_w_en;
            addr_q    <= address;
            data_q    <= data;
            sram_addr <= {idx_in, 1'b0};
         end
         if (state == HI && last)
            sram_addr <= {idx_q, 1'b1};
         if (state == HI && last && !op_w)
            data_memory_out[31:16] <= sram_dq_in;
         if (state == LO && last && !op_w)
            data_memory_out[15:0] <= sram_dq_in;
      end
   end

   // Next-state, wait counter, handshake and SRAM strobe decode
   always_comb begin
      state_nx    = state;
      wait_nx     = wait_cnt;
      ready       = 1'b0;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = '0;
      unique case (state)
         IDLE: begin
            ready = !req;
            if (req) begin
               state_nx = HI;
               wait_nx  = '0;
            end
         end
         HI: begin
            sram_we_n  = !op_w;
            sram_dq_oe = op_w;
            if (op_w) sram_dq_out = data_q[31:16];
            if (last) begin
               state_nx = LO;
               wait_nx  = '0;
            end else begin
               wait_nx = wait_cnt + 4'd1;
            end
         end
         LO: begin
            sram_we_n  = !op_w;
            sram_dq_oe = op_w;
            if (op_w) sram_dq_out = data_q[15:0];
            if (last) begin
               state_nx = DONE;
               wait_nx  = '0;
            end else begin
               wait_nx = wait_cnt + 4'd1;
            end
         end
         DONE: begin
            ready    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench for sram_controller with a W=2
// instance and a W=1 instance sharing one behavioural SRAM.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_en, w_en, r_en2, w_en2;
   logic [31:0] address, data;

   logic [31:0] dmo1, dmo2;
   logic        rdy1, rdy2, we1, we2, oe1, oe2;
   logic [17:0] addr1, addr2;
   logic [15:0] dqo1, dqo2, dqi1, dqi2;

   logic [15:0] mem [0:15];
   logic [31:0] exp_q [$];
   logic [31:0] last1, last2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_controller #(.ADDR_BASE(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(2)) dut1 (
      .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en),
      .address(address), .data(data), .data_memory_out(dmo1),
      .ready(rdy1), .sram_addr(addr1), .sram_we_n(we1),
      .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1)
   );

   sram_controller #(.ADDR_BASE(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)) dut2 (
      .clk(clk), .rst(rst), .mem_r_en(r_en2), .mem_w_en(w_en2),
      .address(address), .data(data), .data_memory_out(dmo2),
      .ready(rdy2), .sram_addr(addr2), .sram_we_n(we2),
      .sram_dq_out(dqo2), .sram_dq_oe(oe2), .sram_dq_in(dqi2)
   );

   // Behavioural asynchronous SRAM: write on strobe, combinational read
   always @(posedge clk) begin
      if (!we1) mem[addr1[3:0]] <= dqo1;
      if (!we2) mem[addr2[3:0]] <= dqo2;
   end
   assign dqi1 = mem[addr1[3:0]];
   assign dqi2 = mem[addr2[3:0]];

   // One request through either instance; checks every cycle to DONE+1
   task automatic run_req(input bit sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int w, input bit tog);
      logic [31:0] off;
      logic [16:0] idx;
      logic [36:0] obs, expv;
      logic [17:0] ea;
      logic [31:0] dm, ed, lst;
      bit done;
      off = a - 32'd1024;
      idx = off[18:2];
      lst = sel ? last2 : last1;
      if (!wr) exp_q.push_back(d);
      @(negedge clk);
      address = a;
      data    = wr ? d : 32'h0;
      if (sel) r_en2 = rd;
      else begin r_en = rd; w_en = wr; end
      #1;
      n_checks++;
      if ((sel ? rdy2 : rdy1) !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_c0 got %b want 0", sel ? rdy2 : rdy1);
      end
      for (int k = 1; k <= 2 * w + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            r_en = 0; w_en = 0; r_en2 = 0;
            if (tog) address = a ^ 32'h0000_0F0C;
         end
         done = (k == 2 * w + 1);
         ea   = (k <= w) ? {idx, 1'b0} : {idx, 1'b1};
         obs  = sel ? {rdy2, addr2, we2, oe2, dqo2}
                    : {rdy1, addr1, we1, oe1, dqo1};
         if (done)
            expv = {1'b1, ea, 1'b1, 1'b0, 16'h0};
         else if (wr)
            expv = {1'b0, ea, 1'b0, 1'b1, (k <= w) ? d[31:16] : d[15:0]};
         else
            expv = {1'b0, ea, 1'b1, 1'b0, 16'h0};
         n_checks++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL cycle%0d rdy/addr/we/oe/dq got %h want %h",
                     k, obs, expv);
         end
         if (done) begin
            dm = sel ? dmo2 : dmo1;
            ed = wr ? lst : exp_q.pop_front();
            n_checks++;
            if (dm !== ed) begin
               n_fail++;
               $display("FAIL done_data got %h want %h", dm, ed);
            end
            lst = ed;
         end
      end
      if (sel) last2 = lst;
      else last1 = lst;
      @(negedge clk);
      dm = sel ? dmo2 : dmo1;
      n_checks++;
      if (dm !== lst || (sel ? rdy2 : rdy1) !== 1'b1) begin
         n_fail++;
         $display("FAIL held_idle data %h rdy %b want %h rdy 1",
                  dm, sel ? rdy2 : rdy1, lst);
      end
   endtask

   task automatic test_reset();
      rst = 1; r_en = 0; w_en = 0; r_en2 = 0; w_en2 = 0;
      address = 0; data = 0;
      last1 = 0; last2 = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      n_checks++;
      if ({rdy1, addr1, we1, oe1, dqo1, dmo1} !==
          {1'b1, 18'h0, 1'b1, 1'b0, 16'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset1 got %b %h %b %b %h %h",
                  rdy1, addr1, we1, oe1, dqo1, dmo1);
      end
      n_checks++;
      if ({rdy2, addr2, we2, oe2, dqo2, dmo2} !==
          {1'b1, 18'h0, 1'b1, 1'b0, 16'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset2 got %b %h %b %b %h %h",
                  rdy2, addr2, we2, oe2, dqo2, dmo2);
      end
   endtask

   task automatic test_write_read();
      run_req(0, 0, 1, 32'd1024, 32'hDEADBEEF, 2, 0);
      run_req(0, 1, 0, 32'd1024, 32'hDEADBEEF, 2, 0);
      run_req(0, 0, 1, 32'd1028, 32'h12345678, 2, 0);
      run_req(0, 1, 0, 32'd1031, 32'h12345678, 2, 0);
   endtask

   task automatic test_both_enables();
      run_req(0, 1, 1, 32'd1032, 32'hA5A55A5A, 2, 1);
      run_req(0, 1, 0, 32'd1032, 32'hA5A55A5A, 2, 0);
   endtask

   task automatic test_wait1();
      run_req(1, 1, 0, 32'd1028, 32'h12345678, 1, 0);
      run_req(1, 1, 0, 32'd1024, 32'hDEADBEEF, 1, 0);
   endtask

   task automatic test_rst_abort();
      @(negedge clk);
      address = 32'd1040; data = 32'hCAFEF00D; w_en = 1;
      @(negedge clk);
      w_en = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      n_checks++;
      if ({rdy1, we1, oe1, dmo1} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL abort got rdy %b we %b oe %b data %h",
                  rdy1, we1, oe1, dmo1);
      end
      r_en = 1;
      #1;
      n_checks++;
      if (rdy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_ready_en got %b want 0", rdy1);
      end
      r_en = 0; rst = 0;
      last1 = 0; last2 = 0;
      @(negedge clk);
      n_checks++;
      if ({rdy1, we1} !== 2'b11) begin
         n_fail++;
         $display("FAIL abort_idle got rdy %b we %b want 1 1", rdy1, we1);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_both_enables();
      test_wait1();
      test_rst_abort();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
